// File: rtl/bcd_display_counter.sv
// bcd_display_counter: four-digit up/down counter that feeds per-digit
// 7-segment decoders. A built-in prescaler sets the step rate: one count
// step every TICK_DIV clocks while enabled. Clear, parallel load and
// enable/direction come from board switches and keys.
//
// Optional build macro: COUNTER_HEX_MODE_EN
//   undefined (default) : BCD digits 0..9, load nibbles above 9 saturate to 9
//   defined             : hex digits 0..F, load nibbles taken unmodified
//
// Priority on every cycle: reset > clear > load > count step.
// Only the count step depends on en; clear and load act regardless of it.
module bcd_display_counter #(
  parameter int TICK_DIV = 50000000,
  parameter int TICK_W   = 26
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        up,
  input  logic        clear,
  input  logic        load,
  input  logic [15:0] load_val,
  output logic [15:0] digits,
  output logic        tick,
  output logic        carry
);

`ifdef COUNTER_HEX_MODE_EN
  localparam logic [3:0] DIG_MAX = 4'hF;
`else
  localparam logic [3:0] DIG_MAX = 4'h9;
`endif

  // Prescaler value on which the next enabled edge applies a count step.
  localparam logic [TICK_W-1:0] PRESC_LAST = TICK_W'(TICK_DIV - 1);

  logic [TICK_W-1:0] r_presc;
  logic [15:0]       r_digits;
  logic              r_tick;
  logic              r_carry;

  logic              w_step;
  logic [15:0]       w_step_digits;
  logic              w_ripple;
  logic [15:0]       w_load_digits;

  assign w_step = en && (r_presc == PRESC_LAST);

  // Next digit value for one step: ripple carry/borrow from digit 0 upward
  // within the same cycle; a ripple out of digit 3 is the wrap indication.
  always_comb begin
    w_step_digits = r_digits;
    w_ripple      = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (w_ripple) begin
        if (up) begin
          if (r_digits[4*i +: 4] == DIG_MAX) begin
            w_step_digits[4*i +: 4] = 4'h0;
          end else begin
            w_step_digits[4*i +: 4] = r_digits[4*i +: 4] + 4'h1;
            w_ripple                = 1'b0;
          end
        end else begin
          if (r_digits[4*i +: 4] == 4'h0) begin
            w_step_digits[4*i +: 4] = DIG_MAX;
          end else begin
            w_step_digits[4*i +: 4] = r_digits[4*i +: 4] - 4'h1;
            w_ripple                = 1'b0;
          end
        end
      end
    end
  end

  // Load value conditioning: saturate each nibble to the digit maximum so
  // the digit register never holds an out-of-range code.
  always_comb begin
    w_load_digits = load_val;
    for (int i = 0; i < 4; i++) begin
      if (load_val[4*i +: 4] > DIG_MAX) begin
        w_load_digits[4*i +: 4] = DIG_MAX;
      end
    end
  end

  // Counter state: prescaler, digits and the registered tick/carry pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_presc  <= '0;
      r_digits <= 16'h0000;
      r_tick   <= 1'b0;
      r_carry  <= 1'b0;
    end else if (clear) begin
      r_presc  <= '0;
      r_digits <= 16'h0000;
      r_tick   <= 1'b0;
      r_carry  <= 1'b0;
    end else if (load) begin
      r_presc  <= '0;
      r_digits <= w_load_digits;
      r_tick   <= 1'b0;
      r_carry  <= 1'b0;
    end else if (w_step) begin
      r_presc  <= '0;
      r_digits <= w_step_digits;
      r_tick   <= 1'b1;
      r_carry  <= w_ripple;
    end else begin
      if (en) begin
        r_presc <= r_presc + TICK_W'(1);
      end
      r_tick  <= 1'b0;
      r_carry <= 1'b0;
    end
  end

  assign digits = r_digits;
  assign tick   = r_tick;
  assign carry  = r_carry;

endmodule
